// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side round-robin arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: IDLE arbitrates every beat, LOCKED holds one owner for a packet.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Round-robin successor of ptr, wrapping from num_req-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        int unsigned nxt;
        if ((ptr + 32'd1) >= num_req) begin
            nxt = 32'd0;
        end else begin
            nxt = ptr + 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational rotating-priority first-one finder: searches req_i starting
// at base_i and wrapping at N-1 -> 0. Returns one-hot, index and any-hit.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] base_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW:0]   sum_s;
    logic [IW:0]   wrap_s;
    logic [IW-1:0] cand_s;

    // Walk candidates base, base+1, ... (mod N) and keep the first requester.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        sum_s    = '0;
        wrap_s   = '0;
        cand_s   = '0;
        for (int i = 0; i < N; i++) begin
            sum_s  = {1'b0, base_i} + (IW+1)'(i);
            wrap_s = sum_s - (IW+1)'(N);
            cand_s = (sum_s >= (IW+1)'(N)) ? wrap_s[IW-1:0] : sum_s[IW-1:0];
            if (!any_o && req_i[cand_s]) begin
                onehot_o[cand_s] = 1'b1;
                idx_o            = cand_s;
                any_o            = 1'b1;
            end else begin
                // An earlier candidate already won; keep it.
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo push port among NUM_REQ
// valid/ready producers. Zero-latency: a beat is pushed in the cycle it is
// accepted. Optional packet locking is enabled by defining
// FIFO_ARB_PKT_LOCK_EN; otherwise arbitration is per beat.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ-1:0]                   req_last_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic [DATA_WIDTH-1:0]                fifo_data_o,
    output logic                                 fifo_push_o,
    input  logic                                 fifo_full_i,
    output logic [NUM_REQ-1:0]                   grant_o,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      ptr_d;
    arb_state_t         state_q;
    logic [IW-1:0]      owner_q;

    logic [NUM_REQ-1:0] pick_onehot_s;
    logic [IW-1:0]      pick_idx_s;
    logic               pick_any_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IW-1:0]      grant_id_s;
    logic               xfer_s;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_picker (
        .req_i    (req_valid_i),
        .base_i   (ptr_q),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s),
        .any_o    (pick_any_s)
    );

    // Current grant: nothing in reset, the lock owner when locked, else the RR pick.
    always_comb begin
        grant_s    = '0;
        grant_id_s = '0;
        if (rst_i) begin
            grant_s    = '0;
            grant_id_s = '0;
        end else if (state_q == LOCKED) begin
            grant_s[owner_q] = 1'b1;
            grant_id_s       = owner_q;
        end else begin
            grant_s    = pick_any_s ? pick_onehot_s : '0;
            grant_id_s = pick_idx_s;
        end
    end

    assign xfer_s      = (|(grant_s & req_valid_i)) & ~fifo_full_i;
    assign fifo_push_o = xfer_s;
    assign req_ready_o = grant_s & {NUM_REQ{~fifo_full_i}};
    assign fifo_data_o = req_data_i[grant_id_s];
    assign grant_o     = grant_s;
    assign grant_id_o  = grant_id_s;

`ifdef FIFO_ARB_PKT_LOCK_EN
    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_t    state_d;
    logic [IW-1:0] owner_d;
    logic [CW-1:0] beat_cnt_q;
    logic [CW-1:0] beat_cnt_d;
    logic          last_s;

    assign last_s = req_last_i[grant_id_s];

    // Packet-lock FSM next state; pointer advances only when a grant is released.
    always_comb begin
        ptr_d      = ptr_q;
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (xfer_s) begin
            case (state_q)
                IDLE: begin
                    if (!last_s && (MAX_BEATS > 1)) begin
                        state_d    = LOCKED;
                        owner_d    = grant_id_s;
                        beat_cnt_d = CW'(1);
                    end else begin
                        ptr_d = IW'(rr_next(32'(grant_id_s), 32'(NUM_REQ)));
                    end
                end
                LOCKED: begin
                    if (last_s || ((beat_cnt_q + CW'(1)) == CW'(MAX_BEATS))) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        ptr_d      = IW'(rr_next(32'(owner_q), 32'(NUM_REQ)));
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end
            endcase
        end else begin
            // No transfer (idle or back-pressured): everything holds.
            state_d = state_q;
        end
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    logic unused_cfg_s;

    assign state_q      = IDLE;
    assign owner_q      = '0;
    assign unused_cfg_s = ^{req_last_i, (MAX_BEATS >= 1)};

    // Per-beat arbitration: advance past the requester that just transferred.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_s) begin
            ptr_d = IW'(rr_next(32'(grant_id_s), 32'(NUM_REQ)));
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic, all compared against a behavioural round-robin/packet model.
// Packet-lock scenarios are included when FIFO_ARB_PKT_LOCK_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic [NR-1:0][DW-1:0]  req_data_i = '0;
    logic [NR-1:0]          req_valid_i = '0;
    logic [NR-1:0]          req_last_i = '0;
    logic [NR-1:0]          req_ready_o;
    logic [DW-1:0]          fifo_data_o;
    logic                   fifo_push_o;
    logic                   fifo_full_i = 1'b0;
    logic [NR-1:0]          grant_o;
    logic [1:0]             grant_id_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_ptr    = 0;
    bit m_locked = 1'b0;
    int m_owner  = 0;
    int m_beats  = 0;
    int pushed_q[$];

    fifo_wr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_data_i  (req_data_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .fifo_data_o (fifo_data_o),
        .fifo_push_o (fifo_push_o),
        .fifo_full_i (fifo_full_i),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                        input logic f, input logic r);
        bit            any;
        int            id;
        logic [NR-1:0] oh;
        bit            push;
        @(negedge clk_i);
        rst_i       = r;
        req_valid_i = v;
        req_last_i  = l;
        fifo_full_i = f;
        for (int k = 0; k < NR; k++) req_data_i[k] = $urandom;
        #1;
        any = 1'b0;
        id  = 0;
        if (r) begin
            any = 1'b0;
        end else if (m_locked) begin
            any = 1'b1;
            id  = m_owner;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (!any && v[(m_ptr + i) % NR]) begin
                    any = 1'b1;
                    id  = (m_ptr + i) % NR;
                end
            end
        end
        oh   = any ? (NR'(1) << id) : '0;
        push = any && v[id] && !f;
        chk("grant", grant_o, oh);
        chk("grant_id", grant_id_o, id);
        chk("ready", req_ready_o, f ? '0 : oh);
        chk("push", fifo_push_o, push);
        if (push) begin
            chk("data", fifo_data_o, req_data_i[id]);
            pushed_q.push_back(id);
        end
        if (r) begin
            m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_beats = 0;
        end else if (push) begin
`ifdef FIFO_ARB_PKT_LOCK_EN
            if (!m_locked) begin
                if (!l[id] && MB > 1) begin
                    m_locked = 1'b1; m_owner = id; m_beats = 1;
                end else begin
                    m_ptr = (id + 1) % NR;
                end
            end else begin
                m_beats++;
                if (l[id] || m_beats == MB) begin
                    m_locked = 1'b0;
                    m_ptr    = (id + 1) % NR;
                end
            end
`else
            m_ptr = (id + 1) % NR;
`endif
        end
        @(posedge clk_i);
    endtask

    task automatic chk_pushed(input string tag, input int exp_q[$]);
        chk({tag, "_len"}, pushed_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pushed_q.size(); i++)
            chk(tag, pushed_q[i], exp_q[i]);
    endtask

    initial begin
        int exp_q[$];

        // Reset: all outputs forced low.
        step('1, '1, 1'b0, 1'b1);
        step('1, '1, 1'b0, 1'b1);

        // All four valid, per-beat packets: 0,1,2,3,0 on consecutive cycles.
        pushed_q.delete();
        for (int i = 0; i < 5; i++) step(4'hF, 4'hF, 1'b0, 1'b0);
        exp_q = {0, 1, 2, 3, 0};
        chk_pushed("rr_all", exp_q);

        // Only req 2 from ptr 0, then req 0 and 3 -> 3 wins.
        step(4'h0, 4'hF, 1'b0, 1'b1);
        pushed_q.delete();
        step(4'b0100, 4'hF, 1'b0, 1'b0);
        step(4'b1001, 4'hF, 1'b0, 1'b0);
        exp_q = {2, 3};
        chk_pushed("rr_skip", exp_q);

        // Full for 3 cycles with req 1 valid, then full drops.
        pushed_q.delete();
        for (int i = 0; i < 3; i++) step(4'b0010, 4'hF, 1'b1, 1'b0);
        chk("full_no_push", pushed_q.size(), 0);
        step(4'b0010, 4'hF, 1'b0, 1'b0);
        exp_q = {1};
        chk_pushed("full_release", exp_q);

`ifdef FIFO_ARB_PKT_LOCK_EN
        // Req 0 sends a 3-beat packet while req 1 waits.
        step(4'h0, 4'h0, 1'b0, 1'b1);
        pushed_q.delete();
        step(4'b0011, 4'b0010, 1'b0, 1'b0);
        step(4'b0011, 4'b0010, 1'b0, 1'b0);
        step(4'b0011, 4'b0011, 1'b0, 1'b0);
        step(4'b0010, 4'b0010, 1'b0, 1'b0);
        exp_q = {0, 0, 0, 1};
        chk_pushed("lock_pkt", exp_q);

        // Req 2 never ends its packet: forced release after MB beats.
        step(4'h0, 4'h0, 1'b0, 1'b1);
        pushed_q.delete();
        for (int i = 0; i < 6; i++) step(4'b1100, 4'b1000, 1'b0, 1'b0);
        exp_q = {2, 2, 2, 2, 3, 2};
        chk_pushed("lock_max", exp_q);
`endif

        // Reset in the middle of traffic restarts arbitration at req 0.
        step(4'h0, 4'h0, 1'b0, 1'b1);
        step(4'b0010, 4'h0, 1'b0, 1'b0);
        step(4'b0010, 4'h0, 1'b0, 1'b0);
        pushed_q.delete();
        step(4'hF, 4'hF, 1'b0, 1'b1);
        step(4'hF, 4'hF, 1'b0, 1'b0);
        exp_q = {0};
        chk_pushed("rst_restart", exp_q);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(NR'($urandom_range(0, 15)), NR'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
